// File: rtl/dcache_miss_controller.sv
// Direct-mapped D-cache miss sequencer: zero-latency read hits, blocking read refill,
// write-through with allocate. Define DCACHE_PERF_CNT_EN to add saturating hit/miss/write counters.
module dcache_miss_controller #(
  parameter int DATA_WIDTH = 32
`ifdef DCACHE_PERF_CNT_EN
  ,
  parameter int CNT_WIDTH  = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [31:0]           ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  input  logic                  CacheHit,
  input  logic [DATA_WIDTH-1:0] CacheData,
  output logic                  CacheFill,
  output logic [31:0]           CacheFillAddr,
  output logic [DATA_WIDTH-1:0] CacheFillData,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt,
  output logic [CNT_WIDTH-1:0]  wr_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    FILL   = 2'd2,
    WR_REQ = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [29:0]           r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rbuf;

  logic w_wr_start;
  logic w_rd_hit;
  logic w_rd_miss;
  logic w_unused_addr_bits;

  // Reset gates the IDLE decode so the pipeline is released while rst is held.
  assign w_wr_start = !rst && MemWriteM;
  assign w_rd_hit   = !rst && !MemWriteM && MemReadM && CacheHit;
  assign w_rd_miss  = !rst && !MemWriteM && MemReadM && !CacheHit;

  assign w_unused_addr_bits = ^ALUResultM[1:0];

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rbuf  <= '0;
    end else begin
      if (r_state == IDLE && (w_wr_start || w_rd_miss)) r_addr <= ALUResultM[31:2];
      if (r_state == IDLE && w_wr_start)                r_wdata <= WriteDataM;
      if (r_state == RD_REQ && mem_ack)                 r_rbuf <= mem_rdata;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_wr_start)     w_next_state = WR_REQ;
        else if (w_rd_miss) w_next_state = RD_REQ;
      end
      RD_REQ:  if (mem_ack) w_next_state = FILL;
      FILL:    w_next_state = IDLE;
      WR_REQ:  if (mem_ack) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    StallM        = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    CacheFill     = 1'b0;
    ReadDataM     = '0;
    CacheFillData = r_rbuf;
    case (r_state)
      IDLE: begin
        StallM = w_wr_start || w_rd_miss;
        if (w_rd_hit) ReadDataM = CacheData;
      end
      RD_REQ: begin
        mem_req = 1'b1;
        StallM  = 1'b1;
      end
      FILL: begin
        CacheFill = 1'b1;
        ReadDataM = r_rbuf;
      end
      WR_REQ: begin
        mem_req       = 1'b1;
        mem_we        = 1'b1;
        StallM        = !mem_ack;
        CacheFill     = mem_ack;
        CacheFillData = r_wdata;
      end
      default: ;
    endcase
  end

  assign mem_addr      = {r_addr, 2'b00};
  assign CacheFillAddr = {r_addr, 2'b00};
  assign mem_wdata     = r_wdata;

`ifdef DCACHE_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_hit_cnt;
  logic [CNT_WIDTH-1:0] r_miss_cnt;
  logic [CNT_WIDTH-1:0] r_wr_cnt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wr_cnt   <= '0;
    end else begin
      if (r_state == IDLE && w_rd_hit)  r_hit_cnt  <= sat_inc(r_hit_cnt);
      if (r_state == FILL)              r_miss_cnt <= sat_inc(r_miss_cnt);
      if (r_state == WR_REQ && mem_ack) r_wr_cnt   <= sat_inc(r_wr_cnt);
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
  assign wr_cnt   = r_wr_cnt;
`endif

endmodule
